mux_scan_sequencer: RTL

MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

---
 rtl/mux_scan_sequencer_pkg.sv | 14 +
 rtl/mux_16x1.sv | 13 +
 rtl/mux_scan_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the 16-channel mux scan sequencer.
package mux_scan_sequencer_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/mux_16x1.sv
// Downstream 16:1 multiplexer scanned by the sequencer (purely combinational).
module mux_16x1 (
  input  logic [15:0] data_inputs,
  input  logic [3:0]  select,
  output logic        output_data
);

  // Pick the selected input bit.
  always_comb begin
    output_data = data_inputs[select];
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an external 16:1 mux through every channel, holding each select value
// SETTLE cycles before sampling, and presents the assembled 16-bit word with a
// valid/ready handshake. Optional continuous mode restarts after each word.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_mode,
  output logic [SEL_W-1:0] select_line,
  input  logic             mux_out,
  output logic [N_CH-1:0]  data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   dout_q, dout_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // Next-state, channel/counter sequencing and sample capture.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          ch_d    = {SEL_W{1'b0}};
          cnt_d   = RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          shadow_d[ch_q] = mux_out;
          if (ch_q == LAST_CH) begin
            // Publish the word including the bit captured this cycle.
            dout_d  = shadow_d;
            state_d = S_OUTPUT;
          end else begin
            ch_d  = ch_q + 4'd1;
            cnt_d = RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_OUTPUT: begin
        if (data_ready) begin
          ch_d = {SEL_W{1'b0}};
          if (cont_mode) begin
            state_d = S_SETTLE;
            cnt_d   = RELOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end
        end else begin
          state_d = S_OUTPUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = {SEL_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output values for the upcoming state so outputs come straight from flops.
  always_comb begin
    sel_d   = {SEL_W{1'b0}};
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        sel_d   = {SEL_W{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      S_SETTLE: begin
        sel_d   = ch_d;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
      S_OUTPUT: begin
        sel_d   = LAST_CH;
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        sel_d   = {SEL_W{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= {SEL_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= {N_CH{1'b0}};
      dout_q   <= {N_CH{1'b0}};
      sel_q    <= {SEL_W{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign select_line = sel_q;
  assign data_out    = dout_q;
  assign data_valid  = valid_q;
  assign busy        = busy_q;

endmodule
